risc_ctrl_seq: RTL and testbench

//  Instruction sequencer for the VeriRISC datapath. Internal 3-bit phase counter

---
 rtl/risc_ctrl_seq_if.sv | 50 +++++
 rtl/risc_ctrl_seq.sv | 127 ++++++++++++
 tb/tb_risc_ctrl_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/risc_ctrl_seq_if.sv
// VeriRISC sequencer bus: IR opcode and zero flag in, datapath strobes out.
// The sequencer is the master; the datapath side is the slave.
interface risc_ctrl_seq_if #(
  parameter int OPCODE_W = 3
);

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                ld_ac;
  logic                ld_pc;
  logic                inc_pc;
  logic                wr;
  logic                data_e;
  logic                halt;
  logic [2:0]          phase;

  modport master (
    input  opcode,
    input  zero,
    output sel,
    output rd,
    output ld_ir,
    output ld_ac,
    output ld_pc,
    output inc_pc,
    output wr,
    output data_e,
    output halt,
    output phase
  );

  modport slave (
    output opcode,
    output zero,
    input  sel,
    input  rd,
    input  ld_ir,
    input  ld_ac,
    input  ld_pc,
    input  inc_pc,
    input  wr,
    input  data_e,
    input  halt,
    input  phase
  );

endinterface

// File: rtl/risc_ctrl_seq.sv
// VeriRISC instruction sequencer: 8-phase counter with opcode decode
// into memory, ACC, PC and bus strobes; optional sticky halt.
module risc_ctrl_seq #(
  parameter int OPCODE_W    = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  risc_ctrl_seq_if.master  bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPCODE_W-1:0] HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] JMP = OPCODE_W'(7);

  phase_e phase_q;
  phase_e phase_d;
  logic   halted_q;
  logic   halted_d;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic aluop;

  assign is_hlt = (bus.opcode == HLT);
  assign is_skz = (bus.opcode == SKZ);
  assign is_sto = (bus.opcode == STO);
  assign is_jmp = (bus.opcode == JMP);
  assign aluop  = (bus.opcode == ADD) | (bus.opcode == AND) |
                  (bus.opcode == XOR) | (bus.opcode == LDA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // A sticky halt parks the counter in OP_ADDR until reset.
  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (HALT_STICKY && phase_q == OP_ADDR && is_hlt) begin
      phase_d  = phase_q;
      halted_d = 1'b1;
    end
  end

  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
        end
        OP_FETCH: begin
          bus.rd = aluop;
        end
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = is_skz & bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.phase = phase_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Bench for risc_ctrl_seq: sticky and non-sticky instances run side by
// side against a rule-based phase model, plus literal per-phase patterns.
module tb_risc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;

  int mp[2];
  bit mh[2];

  logic [8:0] oa[8];
  logic [8:0] ob[8];
  int         pha[8];
  int         phb[8];

  risc_ctrl_seq_if #(.OPCODE_W(3)) ifa ();
  risc_ctrl_seq_if #(.OPCODE_W(3)) ifb ();

  assign ifa.opcode = opcode;
  assign ifa.zero   = zero;
  assign ifb.opcode = opcode;
  assign ifb.zero   = zero;

  risc_ctrl_seq #(.OPCODE_W(3), .HALT_STICKY(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  risc_ctrl_seq #(.OPCODE_W(3), .HALT_STICKY(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  always #5 clk = ~clk;

  // {sel,rd,ld_ir,ld_ac,ld_pc,inc_pc,wr,data_e,halt}
  function automatic logic [8:0] expect_out(int p, int op, bit z, bit h);
    bit alu;
    logic [8:0] r;
    alu = (op >= 2 && op <= 5);
    r = '0;
    if (h) begin
      r[0] = 1'b1;
      return r;
    end
    r[8] = (p <= 3);
    r[7] = (p >= 1 && p <= 3) || (p >= 5 && alu);
    r[6] = (p == 2 || p == 3);
    r[5] = (p == 7 && alu);
    r[4] = (p == 6 || p == 7) && op == 7;
    r[3] = (p == 4) || (p == 6 && op == 1 && z);
    r[2] = (p == 7 && op == 6);
    r[1] = (p == 6 || p == 7) && op == 6;
    r[0] = (p == 4 && op == 0);
    return r;
  endfunction

  function automatic logic [8:0] outs_a();
    return {ifa.sel, ifa.rd, ifa.ld_ir, ifa.ld_ac, ifa.ld_pc,
            ifa.inc_pc, ifa.wr, ifa.data_e, ifa.halt};
  endfunction

  function automatic logic [8:0] outs_b();
    return {ifb.sel, ifb.rd, ifb.ld_ir, ifb.ld_ac, ifb.ld_pc,
            ifb.inc_pc, ifb.wr, ifb.data_e, ifb.halt};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic compare_models();
    logic [8:0] got;
    int         gp;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? outs_a() : outs_b();
      gp  = (i == 0) ? int'(ifa.phase) : int'(ifb.phase);
      check($sformatf("dut%0d_outs_p%0d", i, mp[i]), int'(got),
            int'(expect_out(mp[i], int'(opcode), zero, mh[i])));
      check($sformatf("dut%0d_phase", i), gp, mp[i]);
      check($sformatf("dut%0d_pc_excl", i), int'(got[4] & got[3]), 0);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!mh[i]) begin
        if (i == 0 && mp[i] == 4 && opcode == 3'd0) mh[i] = 1'b1;
        else mp[i] = (mp[i] + 1) % 8;
      end
    end
  endtask

  task automatic cycle(input logic [2:0] op, input logic z,
                       output logic [8:0] ga, output logic [8:0] gb,
                       output int pa, output int pb);
    opcode = op;
    zero   = z;
    #1;
    compare_models();
    ga = outs_a();
    gb = outs_b();
    pa = int'(ifa.phase);
    pb = int'(ifb.phase);
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mp = '{0, 0};
    mh = '{0, 0};
    compare_models();
    @(posedge clk);
    #1;
    compare_models();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) begin
      cycle(op, z, oa[i], ob[i], pha[i], phb[i]);
    end
  endtask

  function automatic logic [7:0] col(int which, int bitn);
    logic [7:0] r;
    for (int p = 0; p < 8; p++) begin
      r[p] = (which == 0) ? oa[p][bitn] : ob[p][bitn];
    end
    return r;
  endfunction

  initial begin
    logic [8:0] ga;
    logic [8:0] gb;
    int         pa;
    int         pb;
    logic [2:0] op;

    rst_n  = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    mp     = '{0, 0};
    mh     = '{0, 0};
    #3;
    compare_models();
    check("rst_outs_lit", int'(outs_a()), 'h100);
    check("rst_phase_lit", int'(ifa.phase), 0);
    #9;
    rst_n = 1'b1;

    // Async reset in the middle of phase 5
    for (int i = 0; i < 5; i++) cycle(3'd5, 1'b0, ga, gb, pa, pb);
    check("pre_abort_phase", int'(ifa.phase), 5);
    rst_n = 1'b0;
    #1;
    check("abort_phase_lit", int'(ifa.phase), 0);
    check("abort_outs_lit", int'(outs_b()), 'h100);
    #1;
    do_reset();

    run_instr(3'd5, 1'b0);
    for (int i = 0; i < 8; i++) check("seq_phase", pha[i], i);
    check("lda_rd", int'(col(0, 7)), 'hEE);
    check("lda_ld_ac", int'(col(0, 5)), 'h80);
    check("lda_inc_pc", int'(col(0, 3)), 'h10);

    run_instr(3'd6, 1'b1);
    check("wrap_phase", pha[0], 0);
    check("sto_data_e", int'(col(0, 1)), 'hC0);
    check("sto_wr", int'(col(0, 2)), 'h80);
    check("sto_rd", int'(col(0, 7)), 'h0E);

    run_instr(3'd7, 1'b1);
    check("jmp_ld_pc", int'(col(0, 4)), 'hC0);
    check("jmp_inc_pc", int'(col(0, 3)), 'h10);

    run_instr(3'd1, 1'b1);
    check("skz_z1_inc_pc", int'(col(1, 3)), 'h50);
    run_instr(3'd1, 1'b0);
    check("skz_z0_inc_pc", int'(col(1, 3)), 'h10);

    // HLT: sticky instance parks, non-sticky pulses once
    run_instr(3'd0, 1'b0);
    check("hlt_b_halt", int'(col(1, 0)), 'h10);
    check("hlt_b_phase7", phb[7], 7);
    check("hlt_a_halt", int'(col(0, 0)), 'hF0);
    check("hlt_a_phase_lit", pha[7], 4);
    for (int i = 0; i < 20; i++) begin
      cycle(3'($urandom_range(7)), 1'($urandom_range(1)), ga, gb, pa, pb);
      check("hlt_stuck_phase", pa, 4);
      check("hlt_stuck_outs", int'(ga), 'h001);
    end
    do_reset();
    check("hlt_clear_phase", int'(ifa.phase), 0);
    check("hlt_clear_outs", int'(outs_a()), 'h100);

    for (int n = 0; n < 300; n++) begin
      if (mh[0] && $urandom_range(2) == 0) do_reset();
      op = 3'($urandom_range(7));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(60) == 0) do_reset();
        cycle(op, 1'($urandom_range(1)), ga, gb, pa, pb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
